// File: rtl/stream_mux_rr.sv
// Registered N-to-1 stream multiplexer with a per-channel valid/ready handshake.
// Supports fixed-select and round-robin modes, with one output register.
module stream_mux_rr #(
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    // Handshake: a word moves whenever valid and ready are both high at a rising
    // edge. Upstream ready never depends on upstream data; the output register
    // refills in the same edge it drains, so a full register only stalls when
    // out_ready is low.

    localparam logic [SEL_W:0] NCH = (SEL_W+1)'(CHANNELS);

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] gnt;
    logic             gnt_ok;
    logic             load;
    logic             xfer;
    logic [SEL_W:0]   cand;

    assign load = !out_valid || out_ready;

    // Round-robin scans starting just after the last channel granted in that mode.
    always_comb begin
        gnt    = '0;
        gnt_ok = 1'b0;
        cand   = '0;
        if (!mode) begin
            if (({1'b0, sel} < NCH) && in_valid[sel]) begin
                gnt    = sel;
                gnt_ok = 1'b1;
            end
        end else begin
            for (int k = 1; k <= CHANNELS; k++) begin
                cand = {1'b0, rr_ptr} + (SEL_W+1)'(k);
                if (cand >= NCH) begin
                    cand = cand - NCH;
                end
                if (!gnt_ok && in_valid[cand[SEL_W-1:0]]) begin
                    gnt    = cand[SEL_W-1:0];
                    gnt_ok = 1'b1;
                end
            end
        end
    end

    assign xfer = !reset && load && gnt_ok;

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            rr_ptr    <= SEL_W'(CHANNELS - 1);
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[gnt*WIDTH +: WIDTH];
            out_chan  <= gnt;
            if (mode) begin
                rr_ptr <= gnt;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised, registered N-to-1 stream multiplexer. It is the next generation of the team's 5-bit 2-to-1 datapath mux.
- Adds a per-channel valid/ready handshake, a one-entry output register, and two selection modes: fixed select and round-robin arbitration.
- Merges several producer streams (e.g. writeback or forwarding sources) onto one consumer in the datapath.

Parameters:
- WIDTH, 5, data bits per channel.
- CHANNELS, 4, number of input channels (2..16).
- SEL_W, 2, select/channel-index width. Must be at least clog2(CHANNELS) and at least 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- mode  input  1  0 = fixed select via sel; 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- in_data  input  CHANNELS*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel data valid.
- in_ready  output  CHANNELS  per-channel accept; combinational.
- out_data  output  WIDTH  registered selected data.
- out_chan  output  SEL_W  registered index of the source channel for out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word this cycle.

Behaviour:
- Reset (async, while reset=1):
  - out_valid=0, out_data=0, out_chan=0, rr_ptr=CHANNELS-1.
  - in_ready forced to all zeros while reset is high.
  - Reset mid-transfer discards the held word with no output.
- Load enable: load = !out_valid || out_ready. A new word may enter the register in the same cycle the old word drains, so throughput is 1 word/cycle.
- Grant, computed combinationally each cycle:
  - mode=0: grant=sel. The grant is valid iff sel<CHANNELS and in_valid[sel]. Other channels are never granted. sel>=CHANNELS gives no grant.
  - mode=1: grant = first i with in_valid[i]=1, scanning (rr_ptr+1), (rr_ptr+2), ... modulo CHANNELS. The grant is valid iff any in_valid bit is set.
- in_ready[i] = load && grant valid && grant==i. At most one bit is ever set (one-hot or zero).
- Transfer: in_valid[g] && in_ready[g] at a rising edge. Then:
  - out_data <= channel g data.
  - out_chan <= g.
  - out_valid <= 1.
- Drain without new transfer: out_valid && out_ready with no transfer sets out_valid <= 0. out_data and out_chan keep their last values.
- Stall: while out_valid && !out_ready, out_data and out_chan are held stable, and in_ready is all zeros.
- Latency: input accepted at edge N appears on out_* after edge N, i.e. 1 cycle.
- rr_ptr:
  - Updates to g only on a transfer made in mode=1.
  - Unchanged in mode=0 and on idle or stall cycles.
  - Wraps modulo CHANNELS.
- Mode/sel changes:
  - Sampled combinationally and take effect on the current cycle's arbitration.
  - Never alter a word already held in the output register.
  - Switching mode does not reset rr_ptr.
- Fairness: in mode=1 with all channels continuously valid and out_ready=1, grants cycle 0,1,2,...,CHANNELS-1,0,...
- No data path from in_data to out_data is combinational. in_ready depends combinationally on in_valid, mode, sel, out_valid and out_ready only.

Test Plan:
- Fixed select, defaults:
  - Stimulus: mode=0, sel=1, ch0=5'b10011, ch1=5'b11111, in_valid=4'b0011, out_ready=1.
  - Required: in_ready=4'b0010; one cycle later out_data=11111, out_chan=1, out_valid=1. Then sel=0 gives out_data=10011, out_chan=0 on the next cycle.
- Round-robin fairness:
  - Stimulus: mode=1, in_valid=4'b1111, ch i = i+1, out_ready=1 for 6 cycles after reset.
  - Required: out_chan sequence 0,1,2,3,0,1 with out_data 1,2,3,4,1,2.
- Backpressure:
  - Stimulus: word accepted, then out_ready=0 for 3 cycles.
  - Required: out_data/out_chan unchanged, out_valid=1, in_ready=0000 throughout. Raising out_ready drains the word and loads the next in the same edge, with no bubble.
- Sparse round-robin with skip:
  - Stimulus: mode=1, in_valid=4'b1010, out_ready=1.
  - Required: grants alternate 1,3,1,3. Then in_valid=4'b0001 gives grant 0.
- Out-of-range/idle:
  - Stimulus: CHANNELS=3, SEL_W=2, mode=0, sel=3, in_valid=3'b111.
  - Required: in_ready=000 and out_valid falls to 0 after the held word drains.
- Async reset mid-stream:
  - Stimulus: assert reset between clock edges while out_valid=1.
  - Required: out_valid=0, out_data=0, out_chan=0 immediately. After release with mode=1 and in_valid=4'b1111, the first grant is channel 0.
